hack_boot_ctrl: RTL

- Sequences the Hack CPU through load, boot and run, and detects halt.
- Receives a program image as a byte stream over a valid/ready handshake and writes it word-by-word into instruction ROM.
- Holds the CPU in reset while loading, releases it, watches the CPU's pc for the canonical halt loop, then freezes the CPU.
- Sits between the host link and the CPU/ROM pair in the top level.

---
 rtl/hack_boot_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/hack_boot_ctrl.sv
// -----------------------------------------------------------------------------
// hack_boot_ctrl
//
// Boot sequencer for the Hack CPU. It pulls a program image from the host link,
// writes it into instruction ROM, pulses the CPU reset and lets the CPU run.
// While the CPU runs it watches the pc for the canonical "jump back to
// yourself" halt loop, and when it sees one it freezes the CPU in reset.
//
// Host stream format: a 2-byte big-endian word count N, then N words, each
// sent high byte first.
//
// Handshake (rx_valid / rx_ready): a byte moves only on a rising edge where
// rx_valid and rx_ready are both high. rx_ready is high only while a header or
// data byte is expected, and is dropped while abort is asserted so that a byte
// is never taken on an edge that discards it. rx_valid is never required to
// wait for rx_ready, and rx_valid without rx_ready consumes nothing.
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   start, rerun, abort    control: load / reboot loaded image / back to IDLE
//   rx_valid, rx_byte      host byte stream in
//   rx_ready               byte accepted on this edge if rx_valid is high
//   cpu_pc                 CPU program counter, watched while running
//   cpu_reset              registered, active-high CPU reset
//   rom_we/addr/wdata      one-cycle ROM write strobe, address and data
//   busy/running/halted/err  status decoded from the state
//   loaded_words           word count of the last complete image
//   dbgState               current state encoding, for debug and checkers
// -----------------------------------------------------------------------------
module hack_boot_ctrl #(
    parameter int ROM_AW      = 15,
    parameter int RST_CYCLES  = 4,
    parameter int HALT_REPEAT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              rerun,
    input  logic              abort,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    input  logic [14:0]       cpu_pc,
    output logic              cpu_reset,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              busy,
    output logic              running,
    output logic              halted,
    output logic              err,
    output logic [15:0]       loaded_words,
    output logic [3:0]        dbgState
);

    localparam int BOOT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int CNT_W  = $clog2(HALT_REPEAT + 1) + 1;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        HDR_HI  = 4'd1,
        HDR_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        BOOT    = 4'd5,
        RUN     = 4'd6,
        HALT    = 4'd7,
        ERR     = 4'd8
    } state_t;

    state_t state, stateNext;

    logic [7:0]        lenHi;
    logic [15:0]       lenReg;
    logic [7:0]        hiByte;
    logic [ROM_AW-1:0] wordIdx;
    logic [BOOT_W-1:0] bootCnt;
    logic [14:0]       prevPc;
    logic [14:0]       loopAddr;
    logic [CNT_W-1:0]  haltCnt;
    logic              pcValid;

    logic        rxAccept;
    logic [15:0] lenFull;
    logic        lenBad;
    logic        lastWord;
    logic        bootDone;
    logic        haltHit;
    logic [14:0] pcBack;
    logic [14:0] loopFwd;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ------------------------------------------------- next state and handshake
    always_comb begin
        stateNext = state;
        rx_ready  = 1'b0;
        rxAccept  = 1'b0;
        lenFull   = {lenHi, rx_byte};
        // A header that is zero or larger than the ROM can hold is rejected
        // before any ROM write happens.
        lenBad    = (lenFull == 16'd0) || ({16'd0, lenFull} > (32'd1 << ROM_AW));
        lastWord  = (32'(wordIdx) == ({16'd0, lenReg} - 32'd1));
        bootDone  = (32'(bootCnt) == RST_CYCLES - 1);
        haltHit   = (32'(haltCnt) >= HALT_REPEAT);

        if (state inside {HDR_HI, HDR_LO, DATA_HI, DATA_LO}) begin
            rx_ready = !abort;
        end
        rxAccept = rx_ready && rx_valid;

        if (abort) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) stateNext = HDR_HI;
                HDR_HI:  if (rxAccept) stateNext = HDR_LO;
                HDR_LO:  if (rxAccept) stateNext = lenBad ? ERR : DATA_HI;
                DATA_HI: if (rxAccept) stateNext = DATA_LO;
                DATA_LO: if (rxAccept) stateNext = lastWord ? BOOT : DATA_HI;
                BOOT:    if (bootDone) stateNext = RUN;
                RUN:     if (haltHit) stateNext = HALT;
                HALT: begin
                    if (start) stateNext = HDR_HI;
                    else if (rerun) stateNext = BOOT;
                end
                ERR:     if (start) stateNext = HDR_HI;
                default: stateNext = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- datapath
    assign pcBack  = prevPc - 15'd1;
    assign loopFwd = loopAddr + 15'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_reset    <= 1'b1;
            rom_we       <= 1'b0;
            rom_addr     <= '0;
            rom_wdata    <= 16'd0;
            loaded_words <= 16'd0;
            lenHi        <= 8'd0;
            lenReg       <= 16'd0;
            hiByte       <= 8'd0;
            wordIdx      <= '0;
            bootCnt      <= '0;
            prevPc       <= 15'd0;
            loopAddr     <= 15'd0;
            haltCnt      <= '0;
            pcValid      <= 1'b0;
        end else begin
            // Registered from the next state so the CPU leaves reset on the
            // same edge that enters RUN and re-enters reset on the edge out.
            cpu_reset <= (stateNext != RUN);
            rom_we    <= 1'b0;

            if (rxAccept) begin
                case (state)
                    HDR_HI:  lenHi <= rx_byte;
                    HDR_LO: begin
                        lenReg  <= lenFull;
                        wordIdx <= '0;
                    end
                    DATA_HI: hiByte <= rx_byte;
                    DATA_LO: begin
                        rom_we    <= 1'b1;
                        rom_addr  <= wordIdx;
                        rom_wdata <= {hiByte, rx_byte};
                        wordIdx   <= wordIdx + 1'b1;
                        if (lastWord) loaded_words <= lenReg;
                    end
                    default: ;
                endcase
            end

            if (state != BOOT) begin
                bootCnt <= '0;
            end else if (stateNext == BOOT) begin
                bootCnt <= bootCnt + 1'b1;
            end

            // Halt detector. Held clear outside RUN; the first RUN cycle only
            // captures the pc because there is no previous pc to compare with.
            if (state != RUN) begin
                prevPc   <= 15'd0;
                loopAddr <= 15'd0;
                haltCnt  <= '0;
                pcValid  <= 1'b0;
            end else begin
                prevPc  <= cpu_pc;
                pcValid <= 1'b1;
                if (pcValid) begin
                    if (cpu_pc == pcBack) begin
                        if (cpu_pc == loopAddr) begin
                            haltCnt <= haltCnt + 1'b1;
                        end else begin
                            loopAddr <= cpu_pc;
                            haltCnt  <= CNT_W'(1);
                        end
                    end else if ((prevPc == loopAddr) && (cpu_pc == loopFwd)) begin
                        // Forward half of the loop: keep the count.
                        haltCnt <= haltCnt;
                    end else begin
                        haltCnt <= '0;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- status
    always_comb begin
        busy    = (state inside {HDR_HI, HDR_LO, DATA_HI, DATA_LO, BOOT});
        running = (state == RUN);
        halted  = (state == HALT);
        err     = (state == ERR);
    end

    assign dbgState = state;

endmodule
